booth_multiplier: RTL and testbench

- Sequential radix-2 Booth multiplier for two's-complement operands of WORD_LENGTH bits.
- Output is sign-magnitude: a WORD_LENGTH-bit magnitude plus a separate sign bit, plus an overflow flag when the magnitude does not fit.
- One Booth step per clock, with a start/ready handshake.
- Used as a datapath arithmetic unit where a multi-cycle multiply is acceptable.

---
 rtl/booth_multiplier.sv | 148 ++++++++++++++
 tb/tb_booth_multiplier.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier with a start/ready handshake.
// Operands are two's-complement; the product is reported as sign plus
// WORD_LENGTH-bit magnitude, with Overflow set when the magnitude does
// not fit in WORD_LENGTH bits. One Booth step is retired per clock.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one add/subtract-and-shift Booth step per cycle
// DONE  | convert {A,Q} to sign-magnitude, raise ready, return to IDLE
module booth_multiplier #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] Multiplicand,
  input  logic [WORD_LENGTH-1:0] Multiplier,
  output logic                   ready,
  output logic                   Sign,
  output logic [WORD_LENGTH-1:0] Result,
  output logic                   Overflow
);

  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(WORD_LENGTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    m_reg;
  logic            q_m1;
  logic [CW-1:0]   count;

  // One guard bit on the Booth adder: A-M with M at the most-negative
  // value leaves the W-bit range, and the shift must replicate the true
  // sign of the sum, not the wrapped one. After halving, A fits again.
  logic [W:0]      a_ext;
  logic [W:0]      m_ext;
  logic [W:0]      sum_ext;

  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  mag;
  logic            prod_neg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Booth add/subtract selected by {Q[0], Q-1}
  always_comb begin
    a_ext   = {a_reg[W-1], a_reg};
    m_ext   = {m_reg[W-1], m_reg};
    sum_ext = a_ext;
    case ({q_reg[0], q_m1})
      2'b01:   sum_ext = a_ext + m_ext;
      2'b10:   sum_ext = a_ext - m_ext;
      default: sum_ext = a_ext;
    endcase
  end

  // Sign-magnitude view of the finished product {A,Q}
  always_comb begin
    prod     = {a_reg, q_reg};
    prod_neg = prod[2*W-1];
    mag      = prod_neg ? (~prod + 1'b1) : prod;
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      q_m1     <= 1'b0;
      count    <= '0;
      ready    <= 1'b0;
      Sign     <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= Multiplicand;
            q_reg <= Multiplier;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= CW'(W);
            ready <= 1'b0;
          end
        end
        RUN: begin
          a_reg <= sum_ext[W:1];
          q_reg <= {sum_ext[0], q_reg[W-1:1]};
          q_m1  <= q_reg[0];
          count <= count - CW'(1);
        end
        DONE: begin
          Sign     <= prod_neg;
          Result   <= mag[W-1:0];
          Overflow <= |mag[2*W-1:W];
          ready    <= 1'b1;
        end
        default: begin
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (WORD_LENGTH = 8).
// Expected values come from plain signed integer multiplication.
module tb_booth_multiplier;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         ready;
  logic         sign_o;
  logic [W-1:0] result_o;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         s;
    logic         o;
  } vec_t;

  vec_t dir_vecs [10];

  logic [W-1:0] bm [30];
  logic [W-1:0] bq [30];

  booth_multiplier #(.WORD_LENGTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .Multiplicand (mcand),
    .Multiplier   (mplier),
    .ready        (ready),
    .Sign         (sign_o),
    .Result       (result_o),
    .Overflow     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_model(input logic [W-1:0] m, input logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic s, output logic o);
    int p;
    int mg;
    p  = $signed(m) * $signed(q);
    s  = (p < 0);
    mg = (p < 0) ? -p : p;
    r  = mg[W-1:0];
    o  = (mg > 255);
  endfunction

  // Drive one multiply; returns edges from acceptance to ready (-1 on timeout).
  task automatic do_mult(input logic [W-1:0] m, input logic [W-1:0] q, output int lat);
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    start = 1'b1;
    mcand = 8'd7;
    mplier = 8'd13;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({ready, sign_o, result_o, ovf_o} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b sign=%b result=%0d ovf=%b, want all 0",
               ready, sign_o, result_o, ovf_o);
    end
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_priority: ready went high after start during reset, want 0");
    end
  endtask

  task automatic test_directed();
    int lat;
    dir_vecs[0] = '{8'd7,   8'd13,  8'd91,  1'b0, 1'b0};
    dir_vecs[1] = '{8'hF9,  8'd13,  8'd91,  1'b1, 1'b0};
    dir_vecs[2] = '{8'hF9,  8'hF3,  8'd91,  1'b0, 1'b0};
    dir_vecs[3] = '{8'd0,   8'hFB,  8'd0,   1'b0, 1'b0};
    dir_vecs[4] = '{8'h80,  8'd1,   8'h80,  1'b1, 1'b0};
    dir_vecs[5] = '{8'd16,  8'd16,  8'd0,   1'b0, 1'b1};
    dir_vecs[6] = '{8'h80,  8'h80,  8'd0,   1'b0, 1'b1};
    dir_vecs[7] = '{8'd1,   8'h80,  8'h80,  1'b1, 1'b0};
    dir_vecs[8] = '{8'h7F,  8'h7F,  8'h01,  1'b0, 1'b1};
    dir_vecs[9] = '{8'h80,  8'h7F,  8'h80,  1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      do_mult(dir_vecs[i].m, dir_vecs[i].q, lat);
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d edges, want %0d", i, lat, W + 1);
      end
      checks++;
      if ({sign_o, result_o, ovf_o} !== {dir_vecs[i].s, dir_vecs[i].r, dir_vecs[i].o}) begin
        errors++;
        $display("FAIL dir_result[%0d] M=%0d Q=%0d: got sign=%b result=%0d ovf=%b, want sign=%b result=%0d ovf=%b",
                 i, $signed(dir_vecs[i].m), $signed(dir_vecs[i].q), sign_o, result_o, ovf_o,
                 dir_vecs[i].s, dir_vecs[i].r, dir_vecs[i].o);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({ready, sign_o, result_o, ovf_o} !== {1'b1, dir_vecs[9].s, dir_vecs[9].r, dir_vecs[9].o}) begin
      errors++;
      $display("FAIL idle_hold: got ready=%b sign=%b result=%0d ovf=%b, want ready=1 sign=%b result=%0d ovf=%b",
               ready, sign_o, result_o, ovf_o, dir_vecs[9].s, dir_vecs[9].r, dir_vecs[9].o);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m, q, er;
    logic es, eo;
    int lat;
    for (int i = 0; i < 40; i++) begin
      m = W'($urandom);
      q = W'($urandom);
      if ($urandom_range(0, 7) == 0) m = 8'h80;
      if ($urandom_range(0, 7) == 0) q = 8'h80;
      ref_model(m, q, er, es, eo);
      do_mult(m, q, lat);
      checks++;
      if (lat != W + 1 || {sign_o, result_o, ovf_o} !== {es, er, eo}) begin
        errors++;
        $display("FAIL rand[%0d] M=%0d Q=%0d: got lat=%0d sign=%b result=%0d ovf=%b, want lat=%0d sign=%b result=%0d ovf=%b",
                 i, $signed(m), $signed(q), lat, sign_o, result_o, ovf_o, W + 1, es, er, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] er;
    logic es, eo;
    int early;
    early = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bm[cyc] = W'($urandom);
      bq[cyc] = W'($urandom);
      mcand  = bm[cyc];
      mplier = bq[cyc];
      @(posedge clk); #1;
      if ((cyc % 10) == 9) begin
        ref_model(bm[cyc - 9], bq[cyc - 9], er, es, eo);
        checks++;
        if ({ready, sign_o, result_o, ovf_o} !== {1'b1, es, er, eo}) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got ready=%b sign=%b result=%0d ovf=%b, want ready=1 sign=%b result=%0d ovf=%b",
                   cyc, ready, sign_o, result_o, ovf_o, es, er, eo);
        end
      end else if ((cyc % 10) == 0 && cyc > 0) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_drop[%0d]: got ready=%b, want 0", cyc, ready);
        end
      end else if (ready !== 1'b0) begin
        early = 1;
      end
    end
    start = 1'b0;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL b2b_ready_early: ready high outside result cycles, want low");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    do_mult(8'd7, 8'd13, lat);
    mcand  = 8'd7;
    mplier = 8'd13;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({ready, sign_o, result_o, ovf_o} !== 11'b0) begin
      errors++;
      $display("FAIL midreset_clear: got ready=%b sign=%b result=%0d ovf=%b, want all 0",
               ready, sign_o, result_o, ovf_o);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_abort: ready rose after aborted op, want 0");
    end
    do_mult(8'd3, 8'hFC, lat);
    checks++;
    if (lat != W + 1 || {sign_o, result_o, ovf_o} !== {1'b1, 8'd12, 1'b0}) begin
      errors++;
      $display("FAIL midreset_next: got lat=%0d sign=%b result=%0d ovf=%b, want lat=9 sign=1 result=12 ovf=0",
               lat, sign_o, result_o, ovf_o);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
